// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer test-pattern writer.
// Pixel word layout matches what the VGA SDRAM reader expects: {pad, R, G, B}.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] pad;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  localparam logic [3:0] GRID_MASK   = 4'h0;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/fb_pattern_writer_if.sv
// Wishbone write-master bus between the pattern writer and the SDRAM arbiter.
// Classic single-beat cycles only; the slave answers with ack.
interface fb_pattern_writer_if;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (
    output adr, dat_ms, we, cyc, stb, sel, cti, bte,
    input  ack
  );

  modport slave (
    input  adr, dat_ms, we, cyc, stb, sel, cti, bte,
    output ack
  );
endinterface

// File: rtl/fb_square_motion.sv
// One axis of the bouncing square: position and direction, stepped once per update pulse.
// The square is clamped flush against either edge when the next step would cross it.
module fb_square_motion #(
  parameter int DISP    = 800,
  parameter int SQ_SIZE = 32,
  parameter int STEP    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  output logic [15:0] pos
);

  localparam logic [31:0] LIMIT  = 32'(DISP - SQ_SIZE);
  localparam logic [31:0] STEP_U = 32'(STEP);

  logic dir_neg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos     <= '0;
      dir_neg <= 1'b0;
    end else if (update) begin
      if (!dir_neg) begin
        if (32'(pos) + STEP_U >= LIMIT) begin
          pos     <= 16'(LIMIT);
          dir_neg <= 1'b1;
        end else begin
          pos <= pos + 16'(STEP);
        end
      end else begin
        if (32'(pos) <= STEP_U) begin
          pos     <= '0;
          dir_neg <= 1'b0;
        end else begin
          pos <= pos - 16'(STEP);
        end
      end
    end
  end

endmodule

// File: rtl/fb_pattern_writer.sv
// Wishbone master that writes one grid + bouncing-square test frame per start pulse.
// One pixel per acked beat; stb/adr/dat hold until ack, no timeout.
module fb_pattern_writer
  import fb_pkg::*;
#(
  parameter int          HDISP    = 800,
  parameter int          VDISP    = 480,
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  parameter int          SQ_SIZE  = 32,
  parameter int          STEP     = 4,
  parameter logic [23:0] SQ_COLOR = 24'hFF0000,
  parameter logic [23:0] BG_COLOR = 24'h202020
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       frame_done,
  fb_pattern_writer_if.master        bus
);

  localparam logic [31:0] HDISP_U = 32'(HDISP);
  localparam logic [31:0] SQ_U    = 32'(SQ_SIZE);
  localparam logic [15:0] X_LAST  = 16'(HDISP - 1);
  localparam logic [15:0] Y_LAST  = 16'(VDISP - 1);

  state_t      state, state_nxt;
  logic [15:0] x, y;
  logic [15:0] pos_x, pos_y;
  logic        beat_done;
  logic        last_px;
  logic        in_sq;
  logic        on_grid;
  pixel_t      pix;

  assign beat_done = (state == WRITE) && bus.ack;
  assign last_px   = (x == X_LAST) && (y == Y_LAST);

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WRITE;
      WRITE:   if (bus.ack && last_px) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs (bus controls drop asynchronously with reset via state)
  always_comb begin
    bus.cyc    = 1'b0;
    bus.stb    = 1'b0;
    bus.we     = 1'b0;
    bus.sel    = 4'h0;
    bus.cti    = CTI_CLASSIC;
    bus.bte    = BTE_LINEAR;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      WRITE: begin
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
        bus.we  = 1'b1;
        bus.sel = 4'hF;
        busy    = 1'b1;
      end
      DONE:    frame_done = 1'b1;
      default: ;
    endcase
  end

  // Raster counters; cleared on the final beat so adr rests at BASE_ADR between frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
    end else if (state == IDLE && start) begin
      x <= '0;
      y <= '0;
    end else if (beat_done) begin
      if (last_px) begin
        x <= '0;
        y <= '0;
      end else if (x == X_LAST) begin
        x <= '0;
        y <= y + 16'd1;
      end else begin
        x <= x + 16'd1;
      end
    end
  end

  assign bus.adr = BASE_ADR + ((32'(x) + 32'(y) * HDISP_U) << 2);

  assign in_sq   = (32'(x) >= 32'(pos_x)) && (32'(x) < 32'(pos_x) + SQ_U) &&
                   (32'(y) >= 32'(pos_y)) && (32'(y) < 32'(pos_y) + SQ_U);
  assign on_grid = (x[3:0] == GRID_MASK) || (y[3:0] == GRID_MASK);

  always_comb begin
    pix = '0;
    if (state == WRITE) begin
      if (in_sq)        {pix.r, pix.g, pix.b} = SQ_COLOR;
      else if (on_grid) {pix.r, pix.g, pix.b} = 24'hFFFFFF;
      else              {pix.r, pix.g, pix.b} = BG_COLOR;
    end
  end

  assign bus.dat_ms = pix;

  fb_square_motion #(
    .DISP    (HDISP),
    .SQ_SIZE (SQ_SIZE),
    .STEP    (STEP)
  ) u_sq_x (
    .clk    (clk),
    .rst    (rst),
    .update (frame_done),
    .pos    (pos_x)
  );

  fb_square_motion #(
    .DISP    (VDISP),
    .SQ_SIZE (SQ_SIZE),
    .STEP    (STEP)
  ) u_sq_y (
    .clk    (clk),
    .rst    (rst),
    .update (frame_done),
    .pos    (pos_y)
  );

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Bench for fb_pattern_writer: small raster, random/fixed slave wait states, reference pixel model.
module tb_fb_pattern_writer;

  localparam int          HDISP    = 32;
  localparam int          VDISP    = 8;
  localparam logic [31:0] BASE_ADR = 32'h0010_0000;
  localparam int          SQ_SIZE  = 4;
  localparam int          STEP     = 10;
  localparam logic [23:0] SQ_COLOR = 24'hFF0000;
  localparam logic [23:0] BG_COLOR = 24'h202020;
  localparam int          NPIX     = HDISP * VDISP;

  logic clk;
  logic rst;
  logic start;
  logic busy;
  logic frame_done;

  fb_pattern_writer_if bus ();

  fb_pattern_writer #(
    .HDISP    (HDISP),
    .VDISP    (VDISP),
    .BASE_ADR (BASE_ADR),
    .SQ_SIZE  (SQ_SIZE),
    .STEP     (STEP),
    .SQ_COLOR (SQ_COLOR),
    .BG_COLOR (BG_COLOR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: square position/direction per axis
  int m_px, m_py;
  bit m_dxn, m_dyn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_pix(input int x, input int y);
    if (x >= m_px && x < m_px + SQ_SIZE && y >= m_py && y < m_py + SQ_SIZE)
      return {8'h00, SQ_COLOR};
    else if (x % 16 == 0 || y % 16 == 0)
      return 32'h00FF_FFFF;
    else
      return {8'h00, BG_COLOR};
  endfunction

  function automatic void model_bounce(inout int pos, inout bit neg, input int disp);
    int lim;
    lim = disp - SQ_SIZE;
    if (!neg) begin
      if (pos + STEP >= lim) begin pos = lim; neg = 1'b1; end
      else pos = pos + STEP;
    end else begin
      if (pos <= STEP) begin pos = 0; neg = 1'b0; end
      else pos = pos - STEP;
    end
  endfunction

  function automatic void model_reset();
    m_px = 0; m_py = 0; m_dxn = 1'b0; m_dyn = 1'b0;
  endfunction

  // Write pixels [0, npix) with nw in [min_w, max_w] wait cycles before each ack.
  // Starts on a negedge; ends on the negedge after the last ack.
  task automatic write_pixels(input int npix, input int min_w, input int max_w,
                              input bit mid_start, output int cycles, output int busy_cnt);
    int ex, ey, nw;
    logic [31:0] exp_adr, exp_dat;
    cycles = 0;
    busy_cnt = 0;
    for (int p = 0; p < npix; p++) begin
      ex = p % HDISP;
      ey = p / HDISP;
      exp_adr = BASE_ADR + 32'(p * 4);
      exp_dat = model_pix(ex, ey);
      nw = $urandom_range(max_w, min_w);
      for (int w = 0; w <= nw; w++) begin
        chk("stb", {31'b0, bus.stb}, 32'd1);
        chk("adr", bus.adr, exp_adr);
        chk("dat", bus.dat_ms, exp_dat);
        cycles++;
        if (busy) busy_cnt++;
        if (w == nw) bus.ack = 1'b1;
        if (mid_start && p == 100 && w == 0) start = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        start = 1'b0;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic full_frame(input int min_w, input int max_w, input bit mid_start,
                            input int exp_cycles);
    int cycles, busy_cnt;
    pulse_start();
    write_pixels(NPIX, min_w, max_w, mid_start, cycles, busy_cnt);
    chk("frame_done", {31'b0, frame_done}, 32'd1);
    chk("busy_in_done", {31'b0, busy}, 32'd0);
    chk("cyc_in_done", {31'b0, bus.cyc}, 32'd0);
    chk("busy_cycles", 32'(busy_cnt), 32'(cycles));
    if (exp_cycles > 0) chk("frame_cycles", 32'(cycles), 32'(exp_cycles));
    model_bounce(m_px, m_dxn, HDISP);
    model_bounce(m_py, m_dyn, VDISP);
    // Idle afterwards: no second frame_done, no queued start, stray ack ignored
    for (int i = 0; i < 4; i++) begin
      bus.ack = (i < 2);
      @(negedge clk);
      chk("idle_done", {31'b0, frame_done}, 32'd0);
      chk("idle_stb", {31'b0, bus.stb}, 32'd0);
      chk("idle_busy", {31'b0, busy}, 32'd0);
      chk("idle_adr", bus.adr, BASE_ADR);
    end
    bus.ack = 1'b0;
  endtask

  initial begin
    int cycles, busy_cnt;
    rst = 1'b0;
    start = 1'b0;
    bus.ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_cyc", {31'b0, bus.cyc}, 32'd0);
    chk("rst_stb", {31'b0, bus.stb}, 32'd0);
    chk("rst_we", {31'b0, bus.we}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, frame_done}, 32'd0);
    chk("rst_adr", bus.adr, BASE_ADR);
    chk("rst_dat", bus.dat_ms, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    full_frame(0, 0, 1'b0, NPIX);          // zero-wait slave
    full_frame(3, 3, 1'b0, 4 * NPIX);      // three waits per beat
    full_frame(0, 2, 1'b1, 0);             // random waits, start retriggered mid-frame
    for (int f = 0; f < 5; f++) full_frame(0, 1, 1'b0, 0);

    // Abort at pixel 100: controls must fall without a clock edge
    pulse_start();
    write_pixels(100, 0, 0, 1'b0, cycles, busy_cnt);
    chk("pre_abort_stb", {31'b0, bus.stb}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_cyc", {31'b0, bus.cyc}, 32'd0);
    chk("abort_stb", {31'b0, bus.stb}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    full_frame(0, 0, 1'b0, NPIX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
